ex_alu_stage: RTL and testbench

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/ex_alu_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_alu_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_alu_stage
//   Execute-stage ALU for an RV32I-style pipeline. Decodes the ALU operation
//   from alu_op/funct3/funct7 combinationally, then captures the ALU result,
//   its zero flag, the branch-taken decision and pc+imm on the next rising
//   clock edge (one cycle of latency, no enable, no handshake).
//
// Ports
//   clk           in   1   clock, all state on the rising edge
//   reset         in   1   synchronous, active-low
//   alu_op        in   2   00 ld/st address, 01 branch, 10 R-type, 11 I-type
//   funct7        in   7   instruction bits [31:25]
//   funct3        in   3   instruction bits [14:12]
//   data0         in  32   operand A (rs1)
//   data1         in  32   operand B (rs2 or immediate)
//   pc            in  32   instruction address
//   imm           in  32   sign-extended immediate
//   alu_ctrl      out  4   decoded operation (combinational)
//   result        out 32   registered ALU result
//   zero_flag     out  1   registered (result == 0)
//   branch        out  1   registered branch-taken
//   branch_target out 32   registered pc + imm
// ---------------------------------------------------------------------------
module ex_alu_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero_flag,
  output logic        branch,
  output logic [31:0] branch_target
);

  typedef enum logic [3:0] {
    CTRL_AND  = 4'b0000,
    CTRL_OR   = 4'b0001,
    CTRL_ADD  = 4'b0010,
    CTRL_XOR  = 4'b0011,
    CTRL_SLL  = 4'b0100,
    CTRL_SRL  = 4'b0101,
    CTRL_SUB  = 4'b0110,
    CTRL_SRA  = 4'b0111,
    CTRL_SLT  = 4'b1000,
    CTRL_SLTU = 4'b1001,
    CTRL_BEQ  = 4'b1010,
    CTRL_BNE  = 4'b1011,
    CTRL_BLT  = 4'b1100,
    CTRL_BGE  = 4'b1101,
    CTRL_BLTU = 4'b1110,
    CTRL_BGEU = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_e;

  alu_ctrl_e   w_ctrl;
  alu_op_e     w_op;
  logic        w_alt;          // funct7[5]: selects SUB / SRA
  logic        w_unused_funct7;
  logic [4:0]  w_shamt;
  logic        w_eq;
  logic        w_lt_s;
  logic        w_lt_u;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_next_result;
  logic        w_next_branch;
  logic [31:0] w_next_target;

  logic [31:0] r_result;
  logic        r_zero;
  logic        r_branch;
  logic [31:0] r_target;

  assign w_op            = alu_op_e'(alu_op);
  assign w_alt           = funct7[5];
  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // ---------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_ctrl = CTRL_ADD;
    unique case (w_op)
      OP_MEM: begin
        w_ctrl = CTRL_ADD;
      end
      OP_BRANCH: begin
        unique case (funct3)
          3'b000:  w_ctrl = CTRL_BEQ;
          3'b001:  w_ctrl = CTRL_BNE;
          3'b100:  w_ctrl = CTRL_BLT;
          3'b101:  w_ctrl = CTRL_BGE;
          3'b110:  w_ctrl = CTRL_BLTU;
          3'b111:  w_ctrl = CTRL_BGEU;
          default: w_ctrl = CTRL_BEQ;   // 010/011 are not branches; fold to BEQ
        endcase
      end
      OP_RTYPE, OP_ITYPE: begin
        unique case (funct3)
          // I-type has no SUBI: funct7 bits there are immediate bits
          3'b000:  w_ctrl = (w_alt && (w_op == OP_RTYPE)) ? CTRL_SUB : CTRL_ADD;
          3'b001:  w_ctrl = CTRL_SLL;
          3'b010:  w_ctrl = CTRL_SLT;
          3'b011:  w_ctrl = CTRL_SLTU;
          3'b100:  w_ctrl = CTRL_XOR;
          3'b101:  w_ctrl = w_alt ? CTRL_SRA : CTRL_SRL;
          3'b110:  w_ctrl = CTRL_OR;
          default: w_ctrl = CTRL_AND;
        endcase
      end
      default: w_ctrl = CTRL_ADD;
    endcase
  end

  assign alu_ctrl = w_ctrl;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  assign w_shamt = data1[4:0];
  assign w_sum   = data0 + data1;
  assign w_diff  = data0 - data1;
  assign w_eq    = (data0 == data1);
  assign w_lt_s  = ($signed(data0) < $signed(data1));
  assign w_lt_u  = (data0 < data1);

  always_comb begin
    w_next_result = '0;
    unique case (w_ctrl)
      CTRL_AND:  w_next_result = data0 & data1;
      CTRL_OR:   w_next_result = data0 | data1;
      CTRL_ADD:  w_next_result = w_sum;
      CTRL_XOR:  w_next_result = data0 ^ data1;
      CTRL_SLL:  w_next_result = data0 << w_shamt;
      CTRL_SRL:  w_next_result = data0 >> w_shamt;
      CTRL_SUB:  w_next_result = w_diff;
      CTRL_SRA:  w_next_result = $unsigned($signed(data0) >>> w_shamt);
      CTRL_SLT:  w_next_result = {31'd0, w_lt_s};
      CTRL_SLTU: w_next_result = {31'd0, w_lt_u};
      default:   w_next_result = w_diff;   // all branch compares
    endcase
  end

  always_comb begin
    w_next_branch = 1'b0;
    unique case (w_ctrl)
      CTRL_BEQ:  w_next_branch = w_eq;
      CTRL_BNE:  w_next_branch = !w_eq;
      CTRL_BLT:  w_next_branch = w_lt_s;
      CTRL_BGE:  w_next_branch = !w_lt_s;
      CTRL_BLTU: w_next_branch = w_lt_u;
      CTRL_BGEU: w_next_branch = !w_lt_u;
      default:   w_next_branch = 1'b0;
    endcase
  end

  assign w_next_target = pc + imm;

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_branch <= 1'b0;
      r_target <= '0;
    end else begin
      r_result <= w_next_result;
      r_zero   <= (w_next_result == '0);
      r_branch <= w_next_branch;
      r_target <= w_next_target;
    end
  end

  assign result        = r_result;
  assign zero_flag     = r_zero;
  assign branch        = r_branch;
  assign branch_target = r_target;

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  alu_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero_flag;
  logic        branch;
  logic [31:0] branch_target;

  typedef struct {
    int unsigned id;
    logic [31:0] res;
    logic        zf;
    logic        br;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int unsigned vec_id = 0;

  ex_alu_stage dut (
    .clk           (clk),
    .reset         (reset),
    .alu_op        (alu_op),
    .funct7        (funct7),
    .funct3        (funct3),
    .data0         (data0),
    .data1         (data1),
    .pc            (pc),
    .imm           (imm),
    .alu_ctrl      (alu_ctrl),
    .result        (result),
    .zero_flag     (zero_flag),
    .branch        (branch),
    .branch_target (branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector after a falling edge, check the combinational decode,
  // and queue the registered response expected after the next rising edge.
  task automatic apply(input logic rst, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im,
                       input logic [3:0] e_ctrl, input logic [31:0] e_res,
                       input logic e_zf, input logic e_br, input logic [31:0] e_tgt);
    exp_t e;
    @(negedge clk);
    reset = rst; alu_op = op; funct7 = f7; funct3 = f3;
    data0 = a; data1 = b; pc = p; imm = im;
    #1;
    n_cmp++;
    if (alu_ctrl !== e_ctrl) begin
      n_bad++;
      $display("FAIL alu_ctrl vec%0d: got %b expected %b", vec_id, alu_ctrl, e_ctrl);
    end
    e.id = vec_id; e.res = e_res; e.zf = e_zf; e.br = e_br; e.tgt = e_tgt;
    q.push_back(e);
    vec_id++;
  endtask

  // Monitor: the stage has a fixed one-cycle latency, so every rising edge
  // that follows a queued vector presents its response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (result !== e.res) begin
          n_bad++;
          $display("FAIL result vec%0d: got %h expected %h", e.id, result, e.res);
        end
        n_cmp++;
        if (zero_flag !== e.zf) begin
          n_bad++;
          $display("FAIL zero_flag vec%0d: got %b expected %b", e.id, zero_flag, e.zf);
        end
        n_cmp++;
        if (branch !== e.br) begin
          n_bad++;
          $display("FAIL branch vec%0d: got %b expected %b", e.id, branch, e.br);
        end
        n_cmp++;
        if (branch_target !== e.tgt) begin
          n_bad++;
          $display("FAIL branch_target vec%0d: got %h expected %h", e.id, branch_target, e.tgt);
        end
      end
    end
  end

  initial begin
    int unsigned waited;
    reset = 1'b0; alu_op = 2'b00; funct7 = '0; funct3 = '0;
    data0 = '0; data1 = '0; pc = '0; imm = '0;

    //     rst  op     f7        f3      data0         data1         pc            imm           ctrl     result        zf    br    target
    // reset state while an ADD is presented
    apply(1'b0, 2'b00, 7'h00, 3'b000, 32'd3,        32'd4,        32'h100,      32'd4,        4'b0010, 32'h0,        1'b1, 1'b0, 32'h0);
    // R-type SUB 5-7
    apply(1'b1, 2'b10, 7'h20, 3'b000, 32'd5,        32'd7,        32'h0,        32'h0,        4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0);
    // BEQ / BNE on equal operands
    apply(1'b1, 2'b01, 7'h00, 3'b000, 32'h1234,     32'h1234,     32'h0,        32'h0,        4'b1010, 32'h0,        1'b1, 1'b1, 32'h0);
    apply(1'b1, 2'b01, 7'h00, 3'b001, 32'h1234,     32'h1234,     32'h0,        32'h0,        4'b1011, 32'h0,        1'b1, 1'b0, 32'h0);
    // BLT vs BLTU with -1 and 1
    apply(1'b1, 2'b01, 7'h00, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1100, 32'hFFFFFFFE, 1'b0, 1'b1, 32'h0);
    apply(1'b1, 2'b01, 7'h00, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1110, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0);
    // BGE (false) / BGEU (true)
    apply(1'b1, 2'b01, 7'h00, 3'b101, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1101, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b01, 7'h00, 3'b111, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1111, 32'hFFFFFFFE, 1'b0, 1'b1, 32'h0);
    // funct3=010 folds to BEQ (unequal -> not taken); BNE taken
    apply(1'b1, 2'b01, 7'h00, 3'b010, 32'd3,        32'd4,        32'h0,        32'h0,        4'b1010, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b01, 7'h00, 3'b001, 32'd3,        32'd4,        32'h0,        32'h0,        4'b1011, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
    // I-type SRAI / SRLI
    apply(1'b1, 2'b11, 7'h20, 3'b101, 32'h80000000, 32'd4,        32'h0,        32'h0,        4'b0111, 32'hF8000000, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b11, 7'h00, 3'b101, 32'h80000000, 32'd4,        32'h0,        32'h0,        4'b0101, 32'h08000000, 1'b0, 1'b0, 32'h0);
    // branch target with negative imm, then wrap
    apply(1'b1, 2'b00, 7'h00, 3'b000, 32'h0,        32'h0,        32'h00000010, 32'hFFFFFFF8, 4'b0010, 32'h0,        1'b1, 1'b0, 32'h00000008);
    apply(1'b1, 2'b00, 7'h7F, 3'b111, 32'h10,       32'h20,       32'hFFFFFFFC, 32'd8,        4'b0010, 32'h30,       1'b0, 1'b0, 32'h00000004);
    // I-type funct3=000 ignores funct7 -> ADD
    apply(1'b1, 2'b11, 7'h20, 3'b000, 32'd5,        32'd7,        32'h0,        32'h0,        4'b0010, 32'd12,       1'b0, 1'b0, 32'h0);
    // SLL uses shamt bits only (0x25 -> 5)
    apply(1'b1, 2'b10, 7'h00, 3'b001, 32'd1,        32'h25,       32'h0,        32'h0,        4'b0100, 32'h20,       1'b0, 1'b0, 32'h0);
    // SLT / SLTU with -1 and 1
    apply(1'b1, 2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1000, 32'd1,        1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b1001, 32'd0,        1'b1, 1'b0, 32'h0);
    // XOR / OR / AND
    apply(1'b1, 2'b10, 7'h00, 3'b100, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,        4'b0011, 32'h0FF0,     1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b10, 7'h00, 3'b110, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,        4'b0001, 32'hFFF0,     1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b10, 7'h00, 3'b111, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,        4'b0000, 32'hF000,     1'b0, 1'b0, 32'h0);
    // R-type SRL by 31, funct7[5]=0 ADD
    apply(1'b1, 2'b10, 7'h00, 3'b101, 32'h80000000, 32'd31,       32'h0,        32'h0,        4'b0101, 32'd1,        1'b0, 1'b0, 32'h0);
    apply(1'b1, 2'b10, 7'h00, 3'b000, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        4'b0010, 32'h0,        1'b1, 1'b0, 32'h0);
    // reset mid-operation, then resume
    apply(1'b0, 2'b00, 7'h00, 3'b000, 32'd3,        32'd4,        32'h40,       32'h4,        4'b0010, 32'h0,        1'b1, 1'b0, 32'h0);
    apply(1'b1, 2'b00, 7'h00, 3'b000, 32'd3,        32'd4,        32'h40,       32'h4,        4'b0010, 32'd7,        1'b0, 1'b0, 32'h44);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
